// File: rtl/result_bcd_display.sv
// ============================================================================
// Module   : result_bcd_display
// Purpose  : Sequential binary-to-BCD converter for the calculator result.
//            Converts a signed two's-complement Result into a sign bit,
//            DIGITS BCD digits and a leading-zero blank mask using one
//            shift-add-3 (double-dabble) step per clock. A new conversion
//            starts automatically whenever Result/Overflow differ from the
//            last accepted snapshot.
// Ports    : clk_i      - system clock (rising edge)
//            rst_i      - asynchronous active-high reset
//            result_i   - W-bit signed result from the calculator core
//            overflow_i - calculator overflow flag
//            sign_o     - 1 = displayed value is negative
//            bcd_o      - DIGITS BCD digits, digit 0 (units) in bits [3:0]
//            blank_o    - bit i = 1 blanks leading-zero digit i
//            err_o      - overflow flag belonging to the displayed value
//            busy_o     - conversion in progress
//            done_o     - one-cycle pulse when new outputs are presented
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_bcd_display #(
  parameter int W      = 22,
  parameter int DIGITS = 7,
  parameter int CW     = $clog2(W + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [W-1:0]          result_i,
  input  logic                  overflow_i,
  output logic                  sign_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic [DIGITS-1:0]     blank_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int BW = 4 * DIGITS;
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic [W-1:0]        snap_r_q, snap_r_d;
  logic                snap_o_q, snap_o_d;
  logic                sign_cap_q, sign_cap_d;
  logic [W-1:0]        shift_q, shift_d;
  logic [BW-1:0]       work_q, work_d;
  logic                sign_q, sign_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [BW-1:0]       work_adj;
  logic [DIGITS-1:0]   lead_zero;
  logic [W-1:0]        magnitude;
  logic                start;

  // Unsigned magnitude: the most negative value maps onto 2^(W-1), which is
  // still representable as an unsigned W-bit number.
  assign magnitude = result_i[W-1] ? (~result_i + W'(1)) : result_i;

  assign start = !valid_q || (result_i != snap_r_q) || (overflow_i != snap_o_q);

  // Add-3 correction applied to every working digit before each shift.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign work_adj[4*gi +: 4] = (work_q[4*gi +: 4] >= 4'd5) ?
                                   (work_q[4*gi +: 4] + 4'd3) : work_q[4*gi +: 4];
    end
  endgenerate

  // Digit i is a leading zero when it and every more-significant digit are 0.
  // The units digit is always shown.
  assign lead_zero[0] = 1'b0;
  generate
    for (gi = 1; gi < DIGITS; gi++) begin : g_blank
      assign lead_zero[gi] = ~|work_q[BW-1:4*gi];
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      snap_r_q   <= '0;
      snap_o_q   <= 1'b0;
      sign_cap_q <= 1'b0;
      shift_q    <= '0;
      work_q     <= '0;
      sign_q     <= 1'b0;
      bcd_q      <= '0;
      blank_q    <= BLANK_RST;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      snap_r_q   <= snap_r_d;
      snap_o_q   <= snap_o_d;
      sign_cap_q <= sign_cap_d;
      shift_q    <= shift_d;
      work_q     <= work_d;
      sign_q     <= sign_d;
      bcd_q      <= bcd_d;
      blank_q    <= blank_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    snap_r_d   = snap_r_q;
    snap_o_d   = snap_o_q;
    sign_cap_d = sign_cap_q;
    shift_d    = shift_q;
    work_d     = work_q;
    sign_d     = sign_q;
    bcd_d      = bcd_q;
    blank_d    = blank_q;
    err_d      = err_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_r_d   = result_i;
          snap_o_d   = overflow_i;
          valid_d    = 1'b1;
          sign_cap_d = result_i[W-1];
          shift_d    = magnitude;
          work_d     = '0;
          cnt_d      = CW'(W);
          busy_d     = 1'b1;
          state_d    = S_CONV;
        end
      end
      S_CONV: begin
        // {digits, magnitude} shifted left by one after the add-3 step.
        work_d  = {work_adj[BW-2:0], shift_q[W-1]};
        shift_d = {shift_q[W-2:0], 1'b0};
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (snap_o_q) begin
          bcd_d   = '1;
          sign_d  = 1'b0;
          blank_d = '1;
        end else begin
          bcd_d   = work_q;
          sign_d  = sign_cap_q;
          blank_d = lead_zero;
        end
        err_d   = snap_o_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign sign_o  = sign_q;
  assign bcd_o   = bcd_q;
  assign blank_o = blank_q;
  assign err_o   = err_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_result_bcd_display.sv
// ============================================================================
// Module   : tb_result_bcd_display
// Purpose  : Self-checking bench for result_bcd_display. Expected displays
//            are computed from the driven inputs by a decimal model and
//            queued; each Done pulse pops and compares one entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_result_bcd_display;

  localparam int W      = 22;
  localparam int DIGITS = 7;
  localparam int BW     = 4 * DIGITS;

  typedef struct {
    logic              sign;
    logic [BW-1:0]     bcd;
    logic [DIGITS-1:0] blank;
    logic              err;
  } exp_t;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [W-1:0]      result_i = '0;
  logic              overflow_i = 1'b0;
  logic              sign_o;
  logic [BW-1:0]     bcd_o;
  logic [DIGITS-1:0] blank_o;
  logic              err_o;
  logic              busy_o;
  logic              done_o;

  int n_checks = 0;
  int n_errors = 0;
  int busy_cyc = 0;
  int done_cyc = 0;
  exp_t sb[$];

  result_bcd_display #(.W(W), .DIGITS(DIGITS)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .result_i   (result_i),
    .overflow_i (overflow_i),
    .sign_o     (sign_o),
    .bcd_o      (bcd_o),
    .blank_o    (blank_o),
    .err_o      (err_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] r, input logic ov);
    exp_t   e;
    longint v;
    logic   seen;
    e.sign  = r[W-1];
    e.err   = ov;
    e.bcd   = '0;
    e.blank = '0;
    v = longint'($signed(r));
    if (v < 0) v = -v;
    for (int i = 0; i < DIGITS; i++) begin
      e.bcd[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (e.bcd[4*i +: 4] != 4'd0) seen = 1'b1;
      e.blank[i] = !seen;
    end
    if (ov) begin
      e.bcd   = '1;
      e.blank = '1;
      e.sign  = 1'b0;
    end
    return e;
  endfunction

  // Scoreboard consumer and activity counters.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (busy_o) busy_cyc++;
      if (done_o) begin
        done_cyc++;
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(done_o), 64'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sign",  64'(sign_o),  64'(e.sign));
          check("bcd",   64'(bcd_o),   64'(e.bcd));
          check("blank", 64'(blank_o), 64'(e.blank));
          check("err",   64'(err_o),   64'(e.err));
        end
      end
    end
  end

  task automatic drive(input logic [W-1:0] r, input logic ov);
    @(negedge clk_i);
    result_i   = r;
    overflow_i = ov;
    sb.push_back(model(r, ov));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && (sb.size() != 0 || busy_o); i++) @(negedge clk_i);
    repeat (2) @(negedge clk_i);
    check("sb_drain", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    logic [W-1:0] vals [3];
    int n;
    int done_before;
    vals[0] = 22'h3FFFFB;   // -5
    vals[1] = 22'h200000;   // -2097152
    vals[2] = 22'h1FFFFF;   // 2097151

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_sign",  64'(sign_o),  64'(0));
    check("rst_bcd",   64'(bcd_o),   64'(0));
    check("rst_blank", 64'(blank_o), 64'(7'b1111110));
    check("rst_err",   64'(err_o),   64'(0));
    check("rst_busy",  64'(busy_o),  64'(0));
    check("rst_done",  64'(done_o),  64'(0));

    // Release with Result=0: one conversion, measured latency
    @(negedge clk_i);
    sb.push_back(model('0, 1'b0));
    rst_i = 1'b0;
    n = 0;
    for (int i = 0; i < 60 && !done_o; i++) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check("rst_latency", 64'(n), 64'(W + 2));
    wait_idle();

    // 1234: outputs hold during conversion, Busy/Done widths
    busy_cyc = 0;
    done_cyc = 0;
    drive(22'd1234, 1'b0);
    repeat (10) @(negedge clk_i);
    check("hold_bcd",  64'(bcd_o),  64'(0));
    check("mid_busy",  64'(busy_o), 64'(1));
    wait_idle();
    check("busy_cycles", 64'(busy_cyc), 64'(W + 1));
    check("done_cycles", 64'(done_cyc), 64'(1));

    // Negative and boundary values
    for (int k = 0; k < 3; k++) begin
      drive(vals[k], 1'b0);
      wait_idle();
    end

    // Stable matched inputs produce no Done
    done_before = done_cyc;
    repeat (40) @(negedge clk_i);
    check("no_spurious_done", 64'(done_cyc), 64'(done_before));

    // Overflow 0->1 with Result unchanged
    drive(22'h1FFFFF, 1'b1);
    wait_idle();

    // Change during conversion: two Done pulses, 42 then 77
    done_cyc = 0;
    drive(22'd42, 1'b0);
    repeat (5) @(negedge clk_i);
    drive(22'd77, 1'b0);
    wait_idle();
    check("two_dones", 64'(done_cyc), 64'(2));

    // Reset mid-conversion: asynchronous clear, then fresh conversion
    drive(22'd555, 1'b0);
    repeat (10) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("arst_bcd",   64'(bcd_o),   64'(0));
    check("arst_blank", 64'(blank_o), 64'(7'b1111110));
    check("arst_busy",  64'(busy_o),  64'(0));
    @(negedge clk_i);
    rst_i = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/result_bcd_display.md
Name: result_bcd_display

Overview:
- Sequential binary-to-BCD converter that sits directly downstream of the four-function calculator core.
- Consumes the core's two's-complement Result and its Overflow flag.
- Produces a sign bit, decimal digits, a leading-zero blank mask and an error flag for the seven-segment drivers.
- Uses an iterative shift-add-3 (double-dabble) algorithm, one bit per clock, and reconverts automatically whenever its inputs change.

Parameters:
- W, 22, width of the Result input (2x the calculator operand width of 11).
- DIGITS, 7, number of BCD digits produced. Must satisfy 10^DIGITS > 2^(W-1).
- CW, $clog2(W+1), width of the internal bit counter.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Result  input  W  signed two's-complement value from the calculator.
- Overflow  input  1  calculator overflow indication.
- Sign  output  1  1 = displayed value is negative.
- BCD  output  4*DIGITS  digit i occupies BCD[4i+3:4i]; digit 0 is the units digit.
- Blank  output  DIGITS  bit i = 1 means digit i is a leading zero and is to be blanked.
- Err  output  1  registered copy of Overflow for the displayed value.
- Busy  output  1  high while a conversion is in progress.
- Done  output  1  one-cycle pulse when new outputs are presented.

Behaviour:
- Reset (asynchronous, any state):
  - Sign=0, BCD=0, Blank = all ones except bit 0 (shows "0"), Err=0, Busy=0, Done=0.
  - FSM goes to IDLE, counter=0, snapshot-valid flag cleared.
- Snapshot registers: SnapR (W bits) and SnapO (1 bit) hold the inputs of the last accepted conversion.
- State IDLE:
  - A conversion starts if the snapshot-valid flag is 0, or if Result != SnapR, or if Overflow != SnapO.
  - On start, the same edge:
    - SnapR<=Result, SnapO<=Overflow, valid<=1.
    - Sign register <= Result[W-1].
    - Shift register <= |Result| as an unsigned W-bit magnitude, in which -2^(W-1) maps to 2^(W-1) with no saturation.
    - BCD working register <= 0, counter <= W, FSM goes to CONV, Busy<=1.
  - Otherwise the FSM stays in IDLE.
- State CONV, one edge per bit:
  - Every working digit >= 5 gets +3 (combinational).
  - Then {working digits, magnitude} shifts left by 1.
  - Counter decrements. When the counter goes 1->0, the FSM moves to DONE.
- State DONE, one edge:
  - BCD <= working digits if SnapO=0, else all digits 4'hF.
  - Sign <= captured sign if SnapO=0, else 0.
  - Err <= SnapO.
  - Blank[i] <= 1 for i>0 when digits i..DIGITS-1 are all zero; Blank[0]=0 always. Blank = all ones when SnapO=1.
  - Done<=1 for exactly the following cycle; Busy<=0; FSM goes to IDLE.
- Latency:
  - Start edge at t, shift edges t+1..t+W, output edge t+W+1.
  - Done is high during cycle t+W+1..t+W+2. For W=22, outputs update 23 edges after the start edge.
- Outputs hold their last values throughout CONV; there are no intermediate glitches.
- Inputs changing during CONV/DONE are ignored. The mismatch against the snapshot is detected in the first IDLE cycle afterwards and starts a new conversion, so the final display always matches the final inputs.
- A Result of zero with sign bit 0 gives Sign=0 (negative zero is impossible in two's complement).
- Inputs that are stable and already matched generate no Done pulses.
- Reset asserted mid-conversion aborts immediately. After release, the valid flag of 0 forces a fresh conversion of the current inputs.
- Counter, digit and shift widths are sized from parameters only; there are no hard-coded 22/7 values.

Test Plan:
- Reset release with Result=0, Overflow=0:
  - One conversion runs, Done pulses 23 edges after the first IDLE edge.
  - BCD=0x0000000, Sign=0, Blank=7'b1111110.
- Result=1234:
  - BCD=0x0001234, Sign=0, Blank=7'b1110000.
  - Busy is high for exactly 23 cycles; Done is high for exactly 1 cycle.
- Result=-5 (22'h3FFFFB) -> BCD=0x0000005, Sign=1, Blank=7'b1111110.
- Result=-2097152 (22'h200000) -> BCD=0x2097152, Sign=1, Blank=0. Result=2097151 -> BCD=0x2097151, Sign=0.
- Overflow 0->1 with Result unchanged -> reconversion runs; then BCD=all 4'hF, Blank=all ones, Err=1, Sign=0.
- Change mid-conversion and reset mid-conversion:
  - Result changes 42->77 at cycle 5 of a conversion: the first Done shows 42, a second conversion follows immediately, and the second Done shows 77.
  - Reset pulsed at cycle 10 of a conversion: outputs go to reset values asynchronously, then a fresh conversion of the current input completes.
